// File: rtl/alu_op_scheduler_if.sv
// Request and response handshake bundle for the ALU issue front-end.
// The producer/consumer side uses master; the scheduler uses slave.
interface alu_op_scheduler_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic [3:0] out_op;
  logic       out_divzero;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_op, out_divzero
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_op, out_divzero
  );
endinterface

// File: rtl/alu_op_scheduler.sv
// Issue front-end for the 8-bit combinational ALU: request FIFO, registered
// operand issue stage and a held result register with valid/ready flow control.
module alu_op_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_op_scheduler_if.slave      bus,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_sel,
  input  logic [7:0]             alu_result,
  input  logic                   alu_carry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_DIV = 4'h3;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  state_t           state;
  state_t           state_next;
  req_t             mem [DEPTH];
  req_t             head_c;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_c;
  logic             pop_c;
  logic             capture_c;
  logic             release_c;
  logic             div_zero_c;
  logic             carry_en_c;

  // Occupancy-based ready: a pop in the same cycle does not free a slot early.
  assign bus.in_ready = (count < CNT_W'(DEPTH));
  assign push_c       = bus.in_valid & bus.in_ready;
  assign head_c       = mem[rd_ptr];
  assign div_zero_c   = (alu_sel == OP_DIV) && (alu_b == 8'h00);
  assign carry_en_c   = (alu_sel == OP_ADD) || (alu_sel == OP_SUB);

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Pops only ever see registered occupancy, so a same-edge push is not bypassed.
  always_comb begin
    state_next = state;
    pop_c      = 1'b0;
    capture_c  = 1'b0;
    release_c  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop_c      = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        capture_c  = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          release_c = 1'b1;
          if (count != '0) begin
            pop_c      = 1'b1;
            state_next = EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
    end else if (pop_c) begin
      alu_a   <= head_c.a;
      alu_b   <= head_c.b;
      alu_sel <= head_c.op;
    end
  end

  // Response register: loaded once per request, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.out_result  <= '0;
      bus.out_carry   <= 1'b0;
      bus.out_op      <= '0;
      bus.out_divzero <= 1'b0;
    end else if (capture_c) begin
      bus.out_valid   <= 1'b1;
      bus.out_op      <= alu_sel;
      bus.out_divzero <= div_zero_c;
      bus.out_result  <= div_zero_c ? 8'hFF : alu_result;
      bus.out_carry   <= carry_en_c & alu_carry;
    end else if (release_c) begin
      bus.out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: behavioural ALU, request/response scoreboard
// and directed plus randomized scenarios.
module tb_alu_op_scheduler;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] res;
    logic       carry;
    logic       dz;
  } resp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic       alu_carry;
  logic       force_carry;
  logic [2:0] count;
  logic [8:0] alu_raw;

  resp_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  alu_op_scheduler_if bus ();

  alu_op_scheduler #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .count      (count)
  );

  // Stand-in ALU; non-arithmetic ops drive a junk carry that must be masked.
  always_comb begin
    case (alu_sel)
      4'h0:    alu_raw = {1'b0, alu_a} + {1'b0, alu_b};
      4'h1:    alu_raw = {1'b0, alu_a} - {1'b0, alu_b};
      4'h2:    alu_raw = {1'b0, alu_a & alu_b};
      4'h3:    alu_raw = (alu_b == 8'h00) ? 9'h100 : {1'b0, alu_a / alu_b};
      4'hE:    alu_raw = {1'b0, alu_a ^ alu_b};
      default: alu_raw = {^alu_a, alu_a | alu_b};
    endcase
  end
  assign alu_result = alu_raw[7:0];
  assign alu_carry  = alu_raw[8] | force_carry;

  function automatic resp_t model(req_t r);
    resp_t p;
    p.op    = r.op;
    p.carry = 1'b0;
    p.dz    = 1'b0;
    case (r.op)
      4'h0: begin
        p.res   = 8'(r.a + r.b);
        p.carry = (int'(r.a) + int'(r.b)) > 255;
      end
      4'h1: begin
        p.res   = 8'(r.a - r.b);
        p.carry = r.a < r.b;
      end
      4'h2: p.res = r.a & r.b;
      4'h3: begin
        if (r.b == 8'h00) begin
          p.res = 8'hFF;
          p.dz  = 1'b1;
        end else begin
          p.res = r.a / r.b;
        end
      end
      4'hE:    p.res = r.a ^ r.b;
      default: p.res = r.a | r.b;
    endcase
    return p;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    case ($urandom_range(0, 5))
      0:       r.op = 4'h0;
      1:       r.op = 4'h1;
      2:       r.op = 4'h2;
      3:       r.op = 4'h3;
      4:       r.op = 4'hE;
      default: r.op = 4'($urandom);
    endcase
    r.a = 8'($urandom);
    r.b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    return r;
  endfunction

  task automatic drive(input bit v, input req_t r);
    bus.in_valid = v;
    bus.in_op    = r.op;
    bus.in_a     = r.a;
    bus.in_b     = r.b;
  endtask

  // One clock from negedge to negedge, recording what the coming edge transfers.
  task automatic tick(output bit pushed, output bit got, output resp_t obs,
                      output bit have, output resp_t e);
    req_t r;
    pushed = bus.in_valid && bus.in_ready;
    got    = bus.out_valid && bus.out_ready;
    obs    = '{op: bus.out_op, res: bus.out_result, carry: bus.out_carry, dz: bus.out_divzero};
    have   = 1'b0;
    e      = '0;
    if (got && exp_q.size() > 0) begin
      have = 1'b1;
      e    = exp_q.pop_front();
    end
    if (pushed) begin
      r = '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
      exp_q.push_back(model(r));
    end
    @(negedge clk);
  endtask

  task automatic send(input req_t r);
    drive(1'b1, r);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({count, bus.in_ready, bus.out_valid, alu_a, alu_b, alu_sel} !== {3'd0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_core: got cnt=%0d rdy=%b ov=%b a=%h b=%h sel=%h, expected 0 1 0 00 00 0",
               count, bus.in_ready, bus.out_valid, alu_a, alu_b, alu_sel);
    end
    n_cmp++;
    if ({bus.out_result, bus.out_carry, bus.out_op, bus.out_divzero} !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_out: got res=%h c=%b op=%h dz=%b, expected all zero",
               bus.out_result, bus.out_carry, bus.out_op, bus.out_divzero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    bus.out_ready = 1'b1;
    drive(1'b1, '{op: 4'h0, a: 8'hF0, b: 8'h20});
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL add_ready: got %b expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({count, bus.out_valid} !== {3'd1, 1'b0}) begin
      n_fail++; $display("FAIL add_accept: got cnt=%0d ov=%b expected 1 0", count, bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({alu_a, alu_b, alu_sel, count, bus.out_valid} !== {8'hF0, 8'h20, 4'h0, 3'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_issue: got a=%h b=%h sel=%h cnt=%0d ov=%b expected f0 20 0 0 0",
               alu_a, alu_b, alu_sel, count, bus.out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_result, bus.out_carry, bus.out_divzero, bus.out_op} !== {1'b1, 8'h10, 1'b1, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL add_result: got ov=%b res=%h c=%b dz=%b op=%h expected 1 10 1 0 0",
               bus.out_valid, bus.out_result, bus.out_carry, bus.out_divzero, bus.out_op);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, count} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL add_release: got ov=%b cnt=%0d expected 0 0", bus.out_valid, count);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_divzero();
    bit ok;
    send('{op: 4'h3, a: 8'd50, b: 8'd0});
    wait_valid(ok);
    n_cmp++;
    if ({ok, bus.out_result, bus.out_divzero, bus.out_carry, bus.out_op} !== {1'b1, 8'hFF, 1'b1, 1'b0, 4'h3}) begin
      n_fail++;
      $display("FAIL div_zero: got ok=%b res=%h dz=%b c=%b op=%h expected 1 ff 1 0 3",
               ok, bus.out_result, bus.out_divzero, bus.out_carry, bus.out_op);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    send('{op: 4'h3, a: 8'd50, b: 8'd7});
    wait_valid(ok);
    n_cmp++;
    if ({ok, bus.out_result, bus.out_divzero, bus.out_carry} !== {1'b1, 8'd7, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL div_normal: got ok=%b res=%h dz=%b c=%b expected 1 07 0 0",
               ok, bus.out_result, bus.out_divzero, bus.out_carry);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_carry_mask();
    bit ok;
    force_carry = 1'b1;
    send('{op: 4'hE, a: 8'hFF, b: 8'h0F});
    wait_valid(ok);
    n_cmp++;
    if ({ok, bus.out_result, bus.out_carry, bus.out_op} !== {1'b1, 8'hF0, 1'b0, 4'hE}) begin
      n_fail++;
      $display("FAIL carry_mask: got ok=%b res=%h c=%b op=%h expected 1 f0 0 e",
               ok, bus.out_result, bus.out_carry, bus.out_op);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    force_carry   = 1'b0;
  endtask

  task automatic test_backpressure();
    req_t  reqs [6];
    int    idx   = 0;
    int    nresp = 0;
    bit    pushed, got, have;
    resp_t obs, e, head;
    exp_q.delete();
    foreach (reqs[i]) reqs[i] = rand_req();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(idx < 6, reqs[(idx < 6) ? idx : 5]);
      tick(pushed, got, obs, have, e);
      if (pushed) idx++;
    end
    n_cmp++;
    if ({count, bus.in_ready, bus.out_valid} !== {3'd4, 1'b0, 1'b1} || idx != 5) begin
      n_fail++;
      $display("FAIL bp_full: got cnt=%0d rdy=%b ov=%b accepted=%0d expected 4 0 1 5",
               count, bus.in_ready, bus.out_valid, idx);
    end
    head = model(reqs[0]);
    n_cmp++;
    if ({bus.out_op, bus.out_result, bus.out_carry, bus.out_divzero} !== {head.op, head.res, head.carry, head.dz}) begin
      n_fail++;
      $display("FAIL bp_hold: got op=%h res=%h expected op=%h res=%h",
               bus.out_op, bus.out_result, head.op, head.res);
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && nresp < 6; c++) begin
      drive(idx < 6, reqs[(idx < 6) ? idx : 5]);
      tick(pushed, got, obs, have, e);
      if (pushed) idx++;
      if (got) begin
        nresp++;
        n_cmp++;
        if (!have || obs !== e) begin
          n_fail++; $display("FAIL bp_resp%0d: got %h expected %h", nresp, obs, e);
        end
      end
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if (nresp != 6 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got %0d responses expected 6", nresp);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_simul_push_pop();
    int    nresp = 0;
    bit    pushed, got, have;
    resp_t obs, e;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, rand_req());
      tick(pushed, got, obs, have, e);
    end
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({count, bus.out_valid} !== {3'd2, 1'b1}) begin
      n_fail++; $display("FAIL sim_setup: got cnt=%0d ov=%b expected 2 1", count, bus.out_valid);
    end
    drive(1'b1, rand_req());
    bus.out_ready = 1'b1;
    tick(pushed, got, obs, have, e);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (count !== 3'd2 || !pushed || !got) begin
      n_fail++; $display("FAIL sim_count: got cnt=%0d push=%b pop=%b expected 2 1 1", count, pushed, got);
    end
    if (got) begin
      nresp++;
      n_cmp++;
      if (!have || obs !== e) begin
        n_fail++; $display("FAIL sim_resp1: got %h expected %h", obs, e);
      end
    end
    for (int c = 0; c < 30 && nresp < 4; c++) begin
      tick(pushed, got, obs, have, e);
      if (got) begin
        nresp++;
        n_cmp++;
        if (!have || obs !== e) begin
          n_fail++; $display("FAIL sim_resp%0d: got %h expected %h", nresp, obs, e);
        end
      end
    end
    n_cmp++;
    if (nresp != 4 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL sim_total: got %0d responses expected 4", nresp);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap_random();
    int    nresp = 0;
    bit    pushed, got, have;
    resp_t obs, e;
    exp_q.delete();
    for (int c = 0; c < 80; c++) begin
      drive($urandom_range(0, 1) == 1, rand_req());
      bus.out_ready = ($urandom_range(0, 9) < 7);
      tick(pushed, got, obs, have, e);
      if (got) begin
        nresp++;
        n_cmp++;
        if (!have || obs !== e) begin
          n_fail++; $display("FAIL rnd_resp%0d: got %h expected %h", nresp, obs, e);
        end
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && (exp_q.size() > 0 || bus.out_valid); c++) begin
      tick(pushed, got, obs, have, e);
      if (got) begin
        nresp++;
        n_cmp++;
        if (!have || obs !== e) begin
          n_fail++; $display("FAIL rnd_resp%0d: got %h expected %h", nresp, obs, e);
        end
      end
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || bus.out_valid !== 1'b0 || count !== 3'd0 || nresp < 10) begin
      n_fail++;
      $display("FAIL rnd_drain: got pending=%0d ov=%b cnt=%0d responses=%0d expected 0 0 0 >=10",
               exp_q.size(), bus.out_valid, count, nresp);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit    pushed, got, have, ok;
    resp_t obs, e;
    exp_q.delete();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, rand_req());
      tick(pushed, got, obs, have, e);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({count, bus.out_valid} !== {3'd3, 1'b1}) begin
      n_fail++; $display("FAIL rst_setup: got cnt=%0d ov=%b expected 3 1", count, bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.out_valid, count, bus.in_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL rst_async: got ov=%b cnt=%0d rdy=%b expected 0 0 1", bus.out_valid, count, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    send('{op: 4'h0, a: 8'h12, b: 8'h34});
    wait_valid(ok);
    n_cmp++;
    if ({ok, bus.out_op, bus.out_result, bus.out_carry, bus.out_divzero} !== {1'b1, 4'h0, 8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after: got ok=%b op=%h res=%h c=%b dz=%b expected 1 0 46 0 0",
               ok, bus.out_op, bus.out_result, bus.out_carry, bus.out_divzero);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, count} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL rst_stale: got ov=%b cnt=%0d expected 0 0", bus.out_valid, count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    force_carry   = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0);
    test_reset();
    test_single_add();
    test_divzero();
    test_carry_mask();
    test_backpressure();
    test_simul_push_pop();
    test_wrap_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
